// File: rtl/tl_grant_client_stage_if.sv
// Grant-client stage bus: arbitrated headered Grant beats in, header-stripped Grant beats
// to the client, and outgoing Finish messages.
interface tl_grant_client_stage_if;
  // Arbitrated Grant channel (from arbiter)
  logic        in_ready;
  logic        in_valid;
  logic [1:0]  in_header_src;
  logic [1:0]  in_header_dst;
  logic [2:0]  in_addr_beat;
  logic        in_client_xact_id;
  logic [1:0]  in_manager_xact_id;
  logic        in_is_builtin_type;
  logic [3:0]  in_g_type;
  logic [63:0] in_data;

  // Client Grant channel
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_addr_beat;
  logic        out_client_xact_id;
  logic [1:0]  out_manager_xact_id;
  logic        out_is_builtin_type;
  logic [3:0]  out_g_type;
  logic [63:0] out_data;

  // Finish channel
  logic        fin_valid;
  logic        fin_ready;
  logic [1:0]  fin_header_src;
  logic [1:0]  fin_header_dst;
  logic [1:0]  fin_manager_xact_id;

  logic        beat_err;

  // Stage side
  modport slave (
    output in_ready,
    input  in_valid, in_header_src, in_header_dst, in_addr_beat, in_client_xact_id,
           in_manager_xact_id, in_is_builtin_type, in_g_type, in_data,
    output out_valid, out_addr_beat, out_client_xact_id, out_manager_xact_id,
           out_is_builtin_type, out_g_type, out_data,
    input  out_ready,
    output fin_valid, fin_header_src, fin_header_dst, fin_manager_xact_id,
    input  fin_ready,
    output beat_err
  );

  // Environment side (arbiter, client and Finish sink)
  modport master (
    input  in_ready,
    output in_valid, in_header_src, in_header_dst, in_addr_beat, in_client_xact_id,
           in_manager_xact_id, in_is_builtin_type, in_g_type, in_data,
    input  out_valid, out_addr_beat, out_client_xact_id, out_manager_xact_id,
           out_is_builtin_type, out_g_type, out_data,
    output out_ready,
    input  fin_valid, fin_header_src, fin_header_dst, fin_manager_xact_id,
    output fin_ready,
    input  beat_err
  );
endinterface

// File: rtl/tl_grant_client_stage.sv
// Grant client stage: buffers arbitrated Grant beats, strips headers, tracks multibeat
// boundaries and queues a Finish for every grant that needs acknowledgment.
module tl_grant_client_stage #(
  parameter int unsigned GNT_DEPTH = 4,
  parameter int unsigned FIN_DEPTH = 2,
  parameter int unsigned BEATS     = 8
) (
  input logic                   clk,
  input logic                   reset,
  tl_grant_client_stage_if.slave bus
);

  localparam int unsigned GPW = $clog2(GNT_DEPTH);
  localparam int unsigned GCW = GPW + 1;
  localparam int unsigned FPW = $clog2(FIN_DEPTH);
  localparam int unsigned FCW = FPW + 1;

  localparam logic [GCW-1:0] GNT_FULL_CNT = GCW'(GNT_DEPTH);
  localparam logic [FCW-1:0] FIN_FULL_CNT = FCW'(FIN_DEPTH);
  localparam logic [2:0]     LAST_BEAT    = 3'(BEATS - 1);

  typedef struct packed {
    logic [2:0]  addr_beat;
    logic        client_xact_id;
    logic [1:0]  manager_xact_id;
    logic        is_builtin_type;
    logic [3:0]  g_type;
    logic [63:0] data;
  } gnt_beat_t;

  typedef struct packed {
    logic [1:0] src;
    logic [1:0] dst;
    logic [1:0] manager_xact_id;
  } fin_msg_t;

  // Storage is intentionally left unreset; only pointers and counts are cleared.
  gnt_beat_t gnt_mem_q [GNT_DEPTH];
  fin_msg_t  fin_mem_q [FIN_DEPTH];

  logic [GPW-1:0] gnt_wr_q, gnt_wr_d, gnt_rd_q, gnt_rd_d;
  logic [GCW-1:0] gnt_cnt_q, gnt_cnt_d;
  logic [FPW-1:0] fin_wr_q, fin_wr_d, fin_rd_q, fin_rd_d;
  logic [FCW-1:0] fin_cnt_q, fin_cnt_d;
  logic [2:0]     beat_q, beat_d;
  logic           beat_err_q, beat_err_d;

  logic      gnt_full, gnt_empty, fin_full, fin_empty;
  logic      fire, multibeat, last, requires_ack;
  logic      gnt_push, gnt_pop, fin_push, fin_pop;
  gnt_beat_t gnt_in, gnt_head;
  fin_msg_t  fin_in, fin_head;

  // Ready depends only on registered occupancy, breaking the arbiter's ready path.
  always_comb begin
    gnt_full  = (gnt_cnt_q == GNT_FULL_CNT);
    gnt_empty = (gnt_cnt_q == '0);
    fin_full  = (fin_cnt_q == FIN_FULL_CNT);
    fin_empty = (fin_cnt_q == '0);
  end

  assign bus.in_ready = !gnt_full && !fin_full;

  always_comb begin
    fire         = bus.in_valid && bus.in_ready;
    multibeat    = (bus.in_is_builtin_type && (bus.in_g_type == 4'd5)) ||
                   (!bus.in_is_builtin_type && (bus.in_g_type == 4'd0));
    last         = !multibeat || (beat_q == LAST_BEAT);
    // Builtin type 0 acknowledges a voluntary release and needs no Finish.
    requires_ack = !(bus.in_is_builtin_type && (bus.in_g_type == 4'd0));
    gnt_push     = fire;
    gnt_pop      = !gnt_empty && bus.out_ready;
    fin_push     = fire && last && requires_ack;
    fin_pop      = !fin_empty && bus.fin_ready;
  end

  always_comb begin
    gnt_in.addr_beat       = bus.in_addr_beat;
    gnt_in.client_xact_id  = bus.in_client_xact_id;
    gnt_in.manager_xact_id = bus.in_manager_xact_id;
    gnt_in.is_builtin_type = bus.in_is_builtin_type;
    gnt_in.g_type          = bus.in_g_type;
    gnt_in.data            = bus.in_data;
    // Finish travels back to the grant's sender, so headers swap.
    fin_in.src             = bus.in_header_dst;
    fin_in.dst             = bus.in_header_src;
    fin_in.manager_xact_id = bus.in_manager_xact_id;
  end

  // Grant FIFO next state
  always_comb begin
    gnt_wr_d  = gnt_wr_q;
    gnt_rd_d  = gnt_rd_q;
    gnt_cnt_d = gnt_cnt_q;
    if (gnt_push) begin
      gnt_wr_d = gnt_wr_q + GPW'(1);
    end
    if (gnt_pop) begin
      gnt_rd_d = gnt_rd_q + GPW'(1);
    end
    case ({gnt_push, gnt_pop})
      2'b10:   gnt_cnt_d = gnt_cnt_q + GCW'(1);
      2'b01:   gnt_cnt_d = gnt_cnt_q - GCW'(1);
      default: gnt_cnt_d = gnt_cnt_q;
    endcase
  end

  // Finish FIFO next state
  always_comb begin
    fin_wr_d  = fin_wr_q;
    fin_rd_d  = fin_rd_q;
    fin_cnt_d = fin_cnt_q;
    if (fin_push) begin
      fin_wr_d = fin_wr_q + FPW'(1);
    end
    if (fin_pop) begin
      fin_rd_d = fin_rd_q + FPW'(1);
    end
    case ({fin_push, fin_pop})
      2'b10:   fin_cnt_d = fin_cnt_q + FCW'(1);
      2'b01:   fin_cnt_d = fin_cnt_q - FCW'(1);
      default: fin_cnt_d = fin_cnt_q;
    endcase
  end

  // Beat tracking; a misnumbered beat is flagged but still accepted and counted.
  always_comb begin
    beat_d     = beat_q;
    beat_err_d = beat_err_q;
    if (fire && multibeat) begin
      beat_d = (beat_q == LAST_BEAT) ? 3'd0 : beat_q + 3'd1;
      if (bus.in_addr_beat != beat_q) begin
        beat_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_wr_q   <= '0;
      gnt_rd_q   <= '0;
      gnt_cnt_q  <= '0;
      fin_wr_q   <= '0;
      fin_rd_q   <= '0;
      fin_cnt_q  <= '0;
      beat_q     <= 3'd0;
      beat_err_q <= 1'b0;
    end else begin
      gnt_wr_q   <= gnt_wr_d;
      gnt_rd_q   <= gnt_rd_d;
      gnt_cnt_q  <= gnt_cnt_d;
      fin_wr_q   <= fin_wr_d;
      fin_rd_q   <= fin_rd_d;
      fin_cnt_q  <= fin_cnt_d;
      beat_q     <= beat_d;
      beat_err_q <= beat_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (gnt_push) begin
      gnt_mem_q[gnt_wr_q] <= gnt_in;
    end
    if (fin_push) begin
      fin_mem_q[fin_wr_q] <= fin_in;
    end
  end

  always_comb begin
    gnt_head = gnt_mem_q[gnt_rd_q];
    fin_head = fin_mem_q[fin_rd_q];
  end

  assign bus.out_valid           = !gnt_empty;
  assign bus.out_addr_beat       = gnt_head.addr_beat;
  assign bus.out_client_xact_id  = gnt_head.client_xact_id;
  assign bus.out_manager_xact_id = gnt_head.manager_xact_id;
  assign bus.out_is_builtin_type = gnt_head.is_builtin_type;
  assign bus.out_g_type          = gnt_head.g_type;
  assign bus.out_data            = gnt_head.data;

  assign bus.fin_valid           = !fin_empty;
  assign bus.fin_header_src      = fin_head.src;
  assign bus.fin_header_dst      = fin_head.dst;
  assign bus.fin_manager_xact_id = fin_head.manager_xact_id;

  assign bus.beat_err = beat_err_q;

endmodule

// File: doc/tl_grant_client_stage.md
Name: tl_grant_client_stage

Overview:
- Sits directly downstream of the locking round-robin Grant-channel arbiter.
- Accepts arbitrated, headered Grant beats; buffers them and presents header-stripped Grant beats to the client port.
- Tracks multibeat grant boundaries and queues a Finish message (manager_xact_id, headers swapped) for every grant that requires acknowledgment.
- Decouples the arbiter's combinational ready path with registered FIFO-state ready.

Parameters:
- GNT_DEPTH, 4, Grant beat FIFO entries (power of 2, ≥2).
- FIN_DEPTH, 2, Finish FIFO entries (power of 2, ≥2).
- BEATS, 8, beats per multibeat grant; beat counter is 3 bits wide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_ready  out  1  beat accepted this cycle when in_valid&in_ready
- in_valid  in  1  arbiter output valid
- in_header_src  in  2  source network id
- in_header_dst  in  2  destination network id
- in_addr_beat  in  3  beat index
- in_client_xact_id  in  1  client transaction id
- in_manager_xact_id  in  2  manager transaction id
- in_is_builtin_type  in  1  builtin grant flag
- in_g_type  in  4  grant type
- in_data  in  64  beat data
- out_valid  out  1  Grant beat to client valid
- out_ready  in  1  client accepts beat
- out_addr_beat, out_client_xact_id, out_manager_xact_id, out_is_builtin_type, out_g_type, out_data  out  3/1/2/1/4/64  buffered payload fields
- fin_valid  out  1  Finish valid
- fin_ready  in  1  Finish accepted
- fin_header_src  out  2  equals grant's in_header_dst
- fin_header_dst  out  2  equals grant's in_header_src
- fin_manager_xact_id  out  2  grant's manager_xact_id
- beat_err  out  1  sticky beat-sequence error

Behaviour:
- Reset: both FIFOs are emptied; beat counter = 0; beat_err = 0; out_valid = 0; fin_valid = 0; in_ready = 1 the cycle after reset deasserts.
- in_ready = !gnt_full & !fin_full. It is a function of registered state only, never of in_valid, in bits, or out_ready.
- Accept: fire = in_valid & in_ready. On fire, all payload fields are written to the Grant FIFO tail. Headers are dropped from the Grant path.
- Multibeat: multibeat = (is_builtin & g_type==5) | (!is_builtin & g_type==0). This is the same rule the upstream arbiter uses to lock.
- Beat counter:
  - On fire of a multibeat beat, counter increments and wraps modulo BEATS (7→0).
  - Single-beat grants leave the counter untouched.
- Last beat: last = !multibeat | (counter == BEATS-1).
- Ack rule: requires_ack = !(is_builtin & g_type==0). Builtin g_type 0 is a voluntary-release ack.
- Finish enqueue: on fire with last & requires_ack, push {src=in_header_dst, dst=in_header_src, manager_xact_id} into the Finish FIFO in the same cycle. Space is guaranteed by in_ready.
- Grant output:
  - out_valid = Grant FIFO not empty. Fields come from the head register.
  - Enqueue-to-out_valid latency is 1 cycle; there is no combinational pass-through.
  - Pop on out_valid & out_ready.
- Finish output: fin_valid = Finish FIFO not empty; pop on fin_valid & fin_ready. Latency is 1 cycle.
- Simultaneous push/pop on a non-full, non-empty FIFO: count is unchanged and pointers both advance.
- Push on full cannot occur because in_ready=0. Pop on empty is ignored.
- Pointers wrap modulo depth. Count width is log2(depth)+1.
- Full-to-not-full: a pop while full makes in_ready=1 in the next cycle, not the same cycle.
- beat_err:
  - Set on fire of a multibeat beat whose in_addr_beat != counter.
  - Stays sticky until reset.
  - The beat is still accepted and counted.
- Mid-operation reset: a partial multibeat grant is discarded and the counter returns to 0. No Finish is generated for the discarded grant.
- FIFO storage is not reset; only pointers and counts are.

Test Plan:
- Single-beat builtin g_type=0, src=1, dst=2: out_valid rises 1 cycle after fire with matching fields; fin_valid stays 0.
- 8-beat builtin g_type=5, addr_beat 0..7, mgr_xact=3, src=2, dst=0, out_ready=1, fin_ready=1: 8 out beats in order. Exactly one Finish {src=0, dst=2, mgr=3}, valid the cycle after beat 7 fires. beat_err stays 0.
- out_ready=0 with 5 beats offered (GNT_DEPTH=4): in_ready drops after the 4th fire. Raise out_ready for 1 cycle: one pop, and in_ready=1 the following cycle.
- fin_ready=0 with three single-beat non-builtin g_type=1 grants: two Finishes queue and in_ready=0 after the 2nd. Release fin_ready: Finishes drain in FIFO order.
- Multibeat grant with beat 3 carrying addr_beat=5: beat_err=1 from the next cycle and sticky. All 8 beats are still delivered.
- Reset asserted after beat 4 of an 8-beat grant: counts=0, out_valid=0, fin_valid=0, beat_err=0. A new 8-beat grant then produces exactly one Finish.
